match_sequencer: RTL

- Match-level controller for the pong game datapath. It sequences each match through idle, serve, play, pause, point and game-over phases.
- Drives the game datapath's restart line and a single-cycle game-step enable (game_tick), which replaces a divided clock.
- Keeps both players' scores, picks the serve direction and declares the winner.
- Sits between the key/debounce front end and the game-state datapath; score and winner feed the display path.

---
 rtl/match_sequencer_if.sv | 24 ++
 rtl/match_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/match_sequencer_if.sv
// match_sequencer_if: key/point inputs and game-control outputs of the match sequencer
//   master: sequencer side (takes keys and point pulses, drives game_rst/game_tick/scores/state)
//   slave : front end / datapath / display side
interface match_sequencer_if;
    logic       start_key;
    logic       pause_key;
    logic       point_left;
    logic       point_right;
    logic       game_rst;
    logic       game_tick;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] winner;
    logic [2:0] state;
    modport master (
        input  start_key, pause_key, point_left, point_right,
        output game_rst, game_tick, serve_dir, score_left, score_right, winner, state
    );
    modport slave (
        output start_key, pause_key, point_left, point_right,
        input  game_rst, game_tick, serve_dir, score_left, score_right, winner, state
    );
endinterface

// File: rtl/match_sequencer.sv
// match_sequencer: pong match controller (idle/serve/play/pause/point/over), scores, game step enable
//   clk        system clock
//   rst        synchronous active-low reset
//   bus.master start_key/pause_key levels (rising edges used), point_left/point_right pulses in;
//              game_rst, game_tick, serve_dir, score_left, score_right, winner, state out (all registered)
module match_sequencer #(
    parameter int TICK_DIV     = 262144,
    parameter int SERVE_CYCLES = 25000000,
    parameter int WIN_SCORE    = 9
) (
    input logic             clk,
    input logic             rst,
    match_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSED = 3'd3, POINT = 3'd4, OVER = 3'd5} state_t;
    localparam int DW = $clog2(TICK_DIV);
    localparam int CW = $clog2(SERVE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SERVE_CYCLES - 1);
    localparam logic [3:0]    WIN_M1   = 4'(WIN_SCORE - 1);
    state_t        st;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic          start_q, pause_q, scorer_left;
    logic          game_rst, game_tick, serve_dir;
    logic [3:0]    score_left, score_right;
    logic [1:0]    winner;
    logic          start_edge, pause_edge, point_win;
    always_comb begin
        start_edge = bus.start_key & ~start_q;
        pause_edge = bus.pause_key & ~pause_q;
        point_win  = (scorer_left ? score_left : score_right) == WIN_M1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= IDLE;
            game_rst    <= 1'b1;
            game_tick   <= 1'b0;
            serve_dir   <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            winner      <= 2'b00;
            div         <= '0;
            cnt         <= '0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            scorer_left <= 1'b0;
        end else begin
            start_q   <= bus.start_key;
            pause_q   <= bus.pause_key;
            game_tick <= 1'b0;
            case (st)
                IDLE: if (start_edge) begin
                    st  <= SERVE;
                    cnt <= CNT_LOAD;
                end
                SERVE: begin
                    game_rst <= 1'b0;
                    if (cnt == '0) begin
                        st  <= PLAY;
                        div <= '0;
                    end else cnt <= cnt - 1'b1;
                end
                PLAY: begin
                    if (bus.point_left && bus.point_right) begin
                        st       <= SERVE;
                        cnt      <= CNT_LOAD;
                        game_rst <= 1'b1;
                    end else if (bus.point_left || bus.point_right) begin
                        scorer_left <= bus.point_left;
                        st          <= POINT;
                    end else if (pause_edge) st <= PAUSED;
                    else begin
                        // divider only advances on cycles that stay in PLAY, so a pause freezes it in place
                        div       <= (div == DIV_MAX) ? '0 : div + 1'b1;
                        game_tick <= div == DIV_MAX;
                    end
                end
                PAUSED: begin
                    if (start_edge) begin
                        st          <= IDLE;
                        score_left  <= '0;
                        score_right <= '0;
                        game_rst    <= 1'b1;
                    end else if (pause_edge) st <= PLAY;
                end
                POINT: begin
                    if (scorer_left) score_left <= score_left + 4'd1;
                    else score_right <= score_right + 4'd1;
                    serve_dir <= scorer_left;
                    st        <= point_win ? OVER : SERVE;
                    winner    <= point_win ? (scorer_left ? 2'b01 : 2'b10) : 2'b00;
                    cnt       <= CNT_LOAD;
                    game_rst  <= 1'b1;
                end
                OVER: if (start_edge) begin
                    st          <= SERVE;
                    score_left  <= '0;
                    score_right <= '0;
                    winner      <= 2'b00;
                    cnt         <= CNT_LOAD;
                end
                default: st <= IDLE;
            endcase
        end
    end
    assign bus.game_rst    = game_rst;
    assign bus.game_tick   = game_tick;
    assign bus.serve_dir   = serve_dir;
    assign bus.score_left  = score_left;
    assign bus.score_right = score_right;
    assign bus.winner      = winner;
    assign bus.state       = st;
endmodule
